// File: rtl/ssd1306_ctrl_seq.sv
// SSD1306 sequencer: panel reset, power-up wait, init command stream, then full-frame pushes over a byte handshake.
// Define SSD1306_TEST_PATTERN_EN to send an AA/55 pattern in place of framebuffer data.
module ssd1306_ctrl_seq #(
  parameter int RST_CYCLES   = 10000,
  parameter int PWRUP_CYCLES = 100000
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_start,
  input  logic       i_refresh,
  output logic       o_oled_rst_n,
  output logic       o_tx_valid,
  output logic [7:0] o_tx_byte,
  output logic       o_tx_dc,
  input  logic       i_tx_ready,
  output logic [9:0] o_fb_addr,
  input  logic [7:0] i_fb_data,
  output logic       o_ready,
  output logic       o_busy
);
  localparam int MAXC = (RST_CYCLES > PWRUP_CYCLES) ? RST_CYCLES : PWRUP_CYCLES;
  localparam int CW   = $clog2(((MAXC > 32) ? MAXC : 32) + 1);
  localparam logic [CW-1:0] ONE       = CW'(1);
  localparam logic [CW-1:0] RST_LAST  = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0] PWR_LAST  = CW'(PWRUP_CYCLES - 1);
  localparam logic [CW-1:0] INIT_LAST = CW'(24);
  localparam logic [CW-1:0] WIN_LAST  = CW'(5);

  typedef enum logic [2:0] {
    OFF, RST_LO, PWR_WAIT, INIT, IDLE, WIN, FB_RD, FB_TX
  } state_t;

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic            r_pend;
  logic            r_oledRstN;
  logic            r_txValid;
  logic [7:0]      r_txByte;
  logic            r_txDc;
  logic [9:0]      r_fbAddr;
  logic            r_ready;
  logic            r_busy;
  logic            w_accept;
  logic [7:0]      w_fbByte;

  function automatic logic [7:0] initByte(input logic [4:0] idx);
    case (idx)
      5'd0:  initByte = 8'hAE;  5'd1:  initByte = 8'hD5;  5'd2:  initByte = 8'h80;
      5'd3:  initByte = 8'hA8;  5'd4:  initByte = 8'h3F;  5'd5:  initByte = 8'hD3;
      5'd6:  initByte = 8'h00;  5'd7:  initByte = 8'h40;  5'd8:  initByte = 8'h8D;
      5'd9:  initByte = 8'h14;  5'd10: initByte = 8'h20;  5'd11: initByte = 8'h00;
      5'd12: initByte = 8'hA1;  5'd13: initByte = 8'hC8;  5'd14: initByte = 8'hDA;
      5'd15: initByte = 8'h12;  5'd16: initByte = 8'h81;  5'd17: initByte = 8'hCF;
      5'd18: initByte = 8'hD9;  5'd19: initByte = 8'hF1;  5'd20: initByte = 8'hDB;
      5'd21: initByte = 8'h40;  5'd22: initByte = 8'hA4;  5'd23: initByte = 8'hA6;
      5'd24: initByte = 8'hAF;
      default: initByte = 8'h00;
    endcase
  endfunction

  // Column 0..127, page 0..7: the whole panel as the write window
  function automatic logic [7:0] winByte(input logic [2:0] idx);
    case (idx)
      3'd0: winByte = 8'h21;  3'd1: winByte = 8'h00;  3'd2: winByte = 8'h7F;
      3'd3: winByte = 8'h22;  3'd4: winByte = 8'h00;  3'd5: winByte = 8'h07;
      default: winByte = 8'h00;
    endcase
  endfunction

`ifdef SSD1306_TEST_PATTERN_EN
  logic w_unused_fb;
  assign w_unused_fb = ^i_fb_data;
  assign w_fbByte    = r_fbAddr[0] ? 8'h55 : 8'hAA;
`else
  assign w_fbByte    = i_fb_data;
`endif

  assign w_accept = r_txValid & i_tx_ready;

  // Framebuffer read data arrives during FB_TX and stays stable while the address is held
  assign o_tx_byte    = (r_state == FB_TX) ? w_fbByte : r_txByte;
  assign o_oled_rst_n = r_oledRstN;
  assign o_tx_valid   = r_txValid;
  assign o_tx_dc      = r_txDc;
  assign o_fb_addr    = r_fbAddr;
  assign o_ready      = r_ready;
  assign o_busy       = r_busy;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= OFF;
      r_cnt      <= '0;
      r_pend     <= 1'b0;
      r_oledRstN <= 1'b0;
      r_txValid  <= 1'b0;
      r_txByte   <= 8'h00;
      r_txDc     <= 1'b0;
      r_fbAddr   <= 10'd0;
      r_ready    <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      if (i_refresh && (r_state != OFF) && (r_state != IDLE)) r_pend <= 1'b1;
      case (r_state)
        OFF: if (i_start) begin
          r_state    <= RST_LO;
          r_cnt      <= '0;
          r_busy     <= 1'b1;
          r_oledRstN <= 1'b0;
        end
        RST_LO: if (r_cnt == RST_LAST) begin
          r_state    <= PWR_WAIT;
          r_cnt      <= '0;
          r_oledRstN <= 1'b1;
        end else begin
          r_cnt <= r_cnt + ONE;
        end
        PWR_WAIT: if (r_cnt == PWR_LAST) begin
          r_state   <= INIT;
          r_cnt     <= '0;
          r_txValid <= 1'b1;
          r_txByte  <= initByte(5'd0);
          r_txDc    <= 1'b0;
        end else begin
          r_cnt <= r_cnt + ONE;
        end
        INIT: if (w_accept) begin
          if (r_cnt == INIT_LAST) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_txValid <= 1'b0;
            r_ready   <= 1'b1;
            r_busy    <= 1'b0;
          end else begin
            r_cnt    <= r_cnt + ONE;
            r_txByte <= initByte(r_cnt[4:0] + 5'd1);
          end
        end
        IDLE: if (i_refresh || r_pend) begin
          r_state   <= WIN;
          r_pend    <= 1'b0;
          r_cnt     <= '0;
          r_ready   <= 1'b0;
          r_busy    <= 1'b1;
          r_txValid <= 1'b1;
          r_txByte  <= winByte(3'd0);
          r_txDc    <= 1'b0;
        end
        WIN: if (w_accept) begin
          if (r_cnt == WIN_LAST) begin
            r_state   <= FB_RD;
            r_cnt     <= '0;
            r_txValid <= 1'b0;
            r_fbAddr  <= 10'd0;
          end else begin
            r_cnt    <= r_cnt + ONE;
            r_txByte <= winByte(r_cnt[2:0] + 3'd1);
          end
        end
        FB_RD: begin
          r_state   <= FB_TX;
          r_txValid <= 1'b1;
          r_txDc    <= 1'b1;
        end
        FB_TX: if (w_accept) begin
          r_txValid <= 1'b0;
          if (r_fbAddr == 10'd1023) begin
            r_state <= IDLE;
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
          end else begin
            r_state  <= FB_RD;
            r_fbAddr <= r_fbAddr + 10'd1;
          end
        end
        default: r_state <= OFF;
      endcase
    end
  end
endmodule
